branch_target_buffer_ctrl: RTL and testbench



---
 rtl/btb_ctrl_pkg.sv | 41 ++++
 rtl/btb_ctrl_table.sv | 33 +++
 rtl/branch_target_buffer_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_branch_target_buffer_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_ctrl_pkg.sv
// Shared types for the branch target buffer controller.
//   - btb_state_e : controller state (INIT walk after reset, RUN, FLUSH walk)
//   - CNT_*       : 2-bit prediction counter encodings
//   - btb_entry_t : one table entry (valid, tag, target, counter)
//   - sat_update  : saturating counter step towards the resolved direction
package btb_ctrl_pkg;

  // Tag and target fields are stored at this width; the controller
  // zero-extends narrower addresses into them.
  localparam int unsigned ADDR_W_MAX = 64;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } btb_state_e;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_MAX-1:0] tag;
    logic [ADDR_W_MAX-1:0] target;
    logic [1:0]            cnt;
  } btb_entry_t;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != CNT_ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btb_ctrl_table.sv
// Register-array storage for the branch target buffer.
//   clk      : clock
//   rd_idx   : combinational read address
//   rd_entry : entry at rd_idx
//   wr_en    : write the whole entry wr_entry at wr_idx
//   clr_en   : clear only the valid bit of entry clr_idx (clear walk)
module btb_ctrl_table
  import btb_ctrl_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output btb_entry_t       rd_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_entry,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx
);

  btb_entry_t mem [ENTRIES];

  // No reset: every valid bit is cleared by the walk before any access.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_entry;
    if (clr_en) mem[clr_idx].valid <= 1'b0;
  end

  assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/branch_target_buffer_ctrl.sv
// Direct-mapped branch target buffer controller.
// Owns the clear walk FSM, the single-slot lookup/update arbiter with a
// starvation bound, the one-deep pending-update register and the
// registered lookup response.
//   btb_ctrl_clk / btb_ctrl_rst_n : clock, asynchronous active-low reset
//   btb_ctrl_flush / btb_ctrl_busy: invalidate-all request, clear walk active
//   btb_ctrl_lookup_*             : fetch lookup request (valid/ready/pc)
//   btb_ctrl_resp_*               : lookup response, one cycle after accept
//   btb_ctrl_upd_*                : resolved-branch update (valid/ready/pc/target/taken)
module branch_target_buffer_ctrl
  import btb_ctrl_pkg::*;
#(
  parameter int unsigned ENTRIES    = 16,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              btb_ctrl_clk,
  input  logic              btb_ctrl_rst_n,
  input  logic              btb_ctrl_flush,
  output logic              btb_ctrl_busy,
  input  logic              btb_ctrl_lookup_valid,
  output logic              btb_ctrl_lookup_ready,
  input  logic [ADDR_W-1:0] btb_ctrl_lookup_pc,
  output logic              btb_ctrl_resp_valid,
  output logic              btb_ctrl_resp_hit,
  output logic [ADDR_W-1:0] btb_ctrl_resp_target,
  output logic [1:0]        btb_ctrl_resp_prediction,
  input  logic              btb_ctrl_upd_valid,
  output logic              btb_ctrl_upd_ready,
  input  logic [ADDR_W-1:0] btb_ctrl_upd_pc,
  input  logic [ADDR_W-1:0] btb_ctrl_upd_target,
  input  logic              btb_ctrl_upd_taken
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] pc);
    return IDX_W'(pc >> 2);
  endfunction

  function automatic logic [ADDR_W_MAX-1:0] tag_of(input logic [ADDR_W-1:0] pc);
    return ADDR_W_MAX'(pc >> (IDX_W + 2));
  endfunction

  btb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  walk_idx_q, walk_idx_d;
  logic              clr_en;

  logic              pend_valid_q;
  logic [ADDR_W-1:0] pend_pc_q;
  logic [ADDR_W-1:0] pend_target_q;
  logic              pend_taken_q;
  logic [STV_W-1:0]  starve_q;

  logic              resp_valid_p1;
  logic              resp_hit_p1;
  logic [ADDR_W-1:0] resp_target_p1;
  logic [1:0]        resp_pred_p1;

  logic              run, lookup_fire, upd_fire, commit;
  logic [IDX_W-1:0]  rd_idx;
  logic [ADDR_W_MAX-1:0] rd_tag;
  logic              rd_hit;
  btb_entry_t        rd_entry, wr_entry;
  logic              wr_en;

  // ---- stage p0: arbitration and table access ----
  assign run         = (state_q == RUN);
  assign lookup_fire = run && btb_ctrl_lookup_valid && (starve_q < STV_W'(STARVE_MAX));
  // Flush drops the pending update, so it must not commit in the flush cycle.
  assign commit      = run && pend_valid_q && !lookup_fire && !btb_ctrl_flush;
  assign upd_fire    = btb_ctrl_upd_ready && btb_ctrl_upd_valid;

  assign btb_ctrl_busy         = !run;
  assign btb_ctrl_lookup_ready = lookup_fire;
  assign btb_ctrl_upd_ready    = run && !pend_valid_q && !btb_ctrl_flush;

  // The single read port serves the lookup when it wins, otherwise the
  // read half of the pending update's read-modify-write.
  assign rd_idx = lookup_fire ? idx_of(btb_ctrl_lookup_pc) : idx_of(pend_pc_q);
  assign rd_tag = lookup_fire ? tag_of(btb_ctrl_lookup_pc) : tag_of(pend_pc_q);
  assign rd_hit = rd_entry.valid && (rd_entry.tag == rd_tag);

  always_comb begin
    wr_en    = 1'b0;
    wr_entry = rd_entry;
    if (commit) begin
      if (rd_hit) begin
        wr_en        = 1'b1;
        wr_entry.cnt = sat_update(rd_entry.cnt, pend_taken_q);
        if (pend_taken_q) wr_entry.target = ADDR_W_MAX'(pend_target_q);
      end else if (pend_taken_q) begin
        // Allocation replaces whatever aliases at this index.
        wr_en           = 1'b1;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = tag_of(pend_pc_q);
        wr_entry.target = ADDR_W_MAX'(pend_target_q);
        wr_entry.cnt    = CNT_WT;
      end
    end
  end

  btb_ctrl_table #(
    .ENTRIES (ENTRIES)
  ) u_table (
    .clk      (btb_ctrl_clk),
    .rd_idx   (rd_idx),
    .rd_entry (rd_entry),
    .wr_en    (wr_en),
    .wr_idx   (idx_of(pend_pc_q)),
    .wr_entry (wr_entry),
    .clr_en   (clr_en),
    .clr_idx  (walk_idx_q)
  );

  always_comb begin
    state_d    = state_q;
    walk_idx_d = walk_idx_q;
    clr_en     = 1'b0;
    unique case (state_q)
      INIT, FLUSH: begin
        clr_en     = 1'b1;
        walk_idx_d = walk_idx_q + 1'b1;
        if (walk_idx_q == IDX_W'(ENTRIES - 1)) state_d = RUN;
      end
      RUN: begin
      end
      default: state_d = INIT;
    endcase
    // Flush from any state (including mid-walk) restarts the walk at 0.
    if (btb_ctrl_flush) begin
      state_d    = FLUSH;
      walk_idx_d = '0;
    end
  end

  // ---- stage p1: registered control and lookup response ----
  always_ff @(posedge btb_ctrl_clk or negedge btb_ctrl_rst_n) begin
    if (!btb_ctrl_rst_n) begin
      state_q        <= INIT;
      walk_idx_q     <= '0;
      pend_valid_q   <= 1'b0;
      starve_q       <= '0;
      resp_valid_p1  <= 1'b0;
      resp_hit_p1    <= 1'b0;
      resp_target_p1 <= '0;
      resp_pred_p1   <= CNT_WNT;
    end else begin
      state_q    <= state_d;
      walk_idx_q <= walk_idx_d;

      if (btb_ctrl_flush || commit) pend_valid_q <= 1'b0;
      else if (upd_fire)            pend_valid_q <= 1'b1;

      if (btb_ctrl_flush || commit)       starve_q <= '0;
      else if (pend_valid_q && lookup_fire) starve_q <= starve_q + 1'b1;

      resp_valid_p1 <= lookup_fire;
      if (lookup_fire) begin
        resp_hit_p1    <= rd_hit;
        resp_target_p1 <= rd_hit ? ADDR_W'(rd_entry.target) : '0;
        resp_pred_p1   <= rd_hit ? rd_entry.cnt : CNT_WNT;
      end
    end
  end

  always_ff @(posedge btb_ctrl_clk) begin
    if (upd_fire) begin
      pend_pc_q     <= btb_ctrl_upd_pc;
      pend_target_q <= btb_ctrl_upd_target;
      pend_taken_q  <= btb_ctrl_upd_taken;
    end
  end

  assign btb_ctrl_resp_valid      = resp_valid_p1;
  assign btb_ctrl_resp_hit        = resp_hit_p1;
  assign btb_ctrl_resp_target     = resp_target_p1;
  assign btb_ctrl_resp_prediction = resp_pred_p1;

endmodule

// File: tb/tb_branch_target_buffer_ctrl.sv
// Self-checking bench for branch_target_buffer_ctrl: directed vector table,
// hand-written corner sequences and randomized traffic, all compared against
// a behavioural model of the table kept in plain arrays.
module tb_branch_target_buffer_ctrl;

  localparam int ENTRIES    = 16;
  localparam int ADDR_W     = 32;
  localparam int STARVE_MAX = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        fl    = 1'b0;
  logic        lv    = 1'b0;
  logic        uv    = 1'b0;
  logic        utk   = 1'b0;
  logic [31:0] lpc   = '0;
  logic [31:0] upc   = '0;
  logic [31:0] utgt  = '0;

  logic        busy, lrdy, rv, rhit, urdy;
  logic [31:0] rtgt;
  logic [1:0]  rpred;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_target_buffer_ctrl #(
    .ENTRIES    (ENTRIES),
    .ADDR_W     (ADDR_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .btb_ctrl_clk             (clk),
    .btb_ctrl_rst_n           (rst_n),
    .btb_ctrl_flush           (fl),
    .btb_ctrl_busy            (busy),
    .btb_ctrl_lookup_valid    (lv),
    .btb_ctrl_lookup_ready    (lrdy),
    .btb_ctrl_lookup_pc       (lpc),
    .btb_ctrl_resp_valid      (rv),
    .btb_ctrl_resp_hit        (rhit),
    .btb_ctrl_resp_target     (rtgt),
    .btb_ctrl_resp_prediction (rpred),
    .btb_ctrl_upd_valid       (uv),
    .btb_ctrl_upd_ready       (urdy),
    .btb_ctrl_upd_pc          (upc),
    .btb_ctrl_upd_target      (utgt),
    .btb_ctrl_upd_taken       (utk)
  );

  // Behavioural model: table contents, pending update, starvation count,
  // cycles of clearing left, and the response expected next cycle.
  bit          m_vld [ENTRIES];
  logic [31:0] m_tag [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  logic [1:0]  m_cnt [ENTRIES];
  bit          p_vld;
  logic [31:0] p_pc, p_tgt;
  bit          p_tk;
  int          starve;
  int          walk_left;
  bit          e_rv, e_hit;
  logic [31:0] e_tgt;
  logic [1:0]  e_pred;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  // One clock cycle: check outputs against the model for the inputs now
  // applied, advance the model, then step to just after the next edge.
  task automatic tick();
    bit run, lfire, ufire, commit;
    int li, pi;
    #1;
    run    = (walk_left == 0);
    lfire  = run && lv && (starve < STARVE_MAX);
    ufire  = run && !p_vld && !fl && uv;
    commit = run && p_vld && !lfire && !fl;
    chk("busy", 64'(busy), 64'(!run));
    if (lv || !run) chk("lookup_ready", 64'(lrdy), 64'(lfire));
    chk("upd_ready", 64'(urdy), 64'(run && !p_vld && !fl));
    chk("resp_valid", 64'(rv), 64'(e_rv));
    if (e_rv) begin
      chk("resp_hit", 64'(rhit), 64'(e_hit));
      chk("resp_target", 64'(rtgt), 64'(e_tgt));
      chk("resp_prediction", 64'(rpred), 64'(e_pred));
    end
    e_rv = lfire;
    if (lfire) begin
      li     = idx_of(lpc);
      e_hit  = m_vld[li] && (m_tag[li] == (lpc >> 6));
      e_tgt  = e_hit ? m_tgt[li] : 32'd0;
      e_pred = e_hit ? m_cnt[li] : 2'b01;
    end
    if (commit) begin
      pi = idx_of(p_pc);
      if (m_vld[pi] && (m_tag[pi] == (p_pc >> 6))) begin
        if (p_tk) begin
          if (m_cnt[pi] != 2'd3) m_cnt[pi] = m_cnt[pi] + 2'd1;
          m_tgt[pi] = p_tgt;
        end else if (m_cnt[pi] != 2'd0) begin
          m_cnt[pi] = m_cnt[pi] - 2'd1;
        end
      end else if (p_tk) begin
        m_vld[pi] = 1'b1;
        m_tag[pi] = p_pc >> 6;
        m_tgt[pi] = p_tgt;
        m_cnt[pi] = 2'd2;
      end
      p_vld  = 1'b0;
      starve = 0;
    end else if (p_vld && lfire) begin
      starve++;
    end
    if (ufire) begin
      p_vld = 1'b1;
      p_pc  = upc;
      p_tgt = utgt;
      p_tk  = utk;
    end
    if (!run) walk_left--;
    if (fl) begin
      walk_left = ENTRIES;
      p_vld     = 1'b0;
      starve    = 0;
      for (int i = 0; i < ENTRIES; i++) m_vld[i] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_lookup_ready", 64'(lrdy), 64'd0);
    chk("rst_upd_ready", 64'(urdy), 64'd0);
    chk("rst_resp_valid", 64'(rv), 64'd0);
    chk("rst_resp_hit", 64'(rhit), 64'd0);
    chk("rst_resp_target", 64'(rtgt), 64'd0);
    chk("rst_resp_prediction", 64'(rpred), 64'd1);
    p_vld     = 1'b0;
    starve    = 0;
    walk_left = ENTRIES;
    e_rv      = 1'b0;
    for (int i = 0; i < ENTRIES; i++) m_vld[i] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Present an update until accepted; optionally give it an idle cycle to commit.
  task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt, input bit tk,
                           input bit wait_commit);
    int n;
    n = 0;
    lv = 1'b0; uv = 1'b1; upc = pc; utgt = tgt; utk = tk;
    #1;
    while (!urdy && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) timeout("upd_accept");
    tick();
    uv = 1'b0;
    if (wait_commit) tick();
  endtask

  task automatic do_lookup(input logic [31:0] pc, input bit xh, input logic [31:0] xt,
                           input logic [1:0] xp);
    int n;
    n = 0;
    lv = 1'b1; lpc = pc;
    #1;
    while (!lrdy && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) timeout("lookup_accept");
    tick();
    lv = 1'b0;
    chk("lkp_resp_valid", 64'(rv), 64'd1);
    chk("lkp_hit", 64'(rhit), 64'(xh));
    chk("lkp_target", 64'(rtgt), 64'(xt));
    chk("lkp_prediction", 64'(rpred), 64'(xp));
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] tg;
    case ($urandom_range(0, 3))
      0:       tg = 32'd0;
      1:       tg = 32'd1;
      2:       tg = 32'd2;
      default: tg = 32'h0200_0001;
    endcase
    return (tg << 6) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  typedef struct {
    bit          is_upd;
    logic [31:0] pc;
    logic [31:0] tgt;
    bit          tk;
    bit          x_hit;
    logic [31:0] x_tgt;
    logic [1:0]  x_pred;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit u, input logic [31:0] pc, input logic [31:0] tgt,
                              input bit tk, input bit h, input logic [31:0] t,
                              input logic [1:0] p);
    vec_t v;
    v.is_upd = u; v.pc = pc; v.tgt = tgt; v.tk = tk;
    v.x_hit = h; v.x_tgt = t; v.x_pred = p;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [5:0] pat;

    vecs.push_back(mk(0, 32'h100, 0, 0, 0, 32'h0,   2'b01));
    vecs.push_back(mk(1, 32'h100, 32'h200, 1, 0, 0, 0));
    vecs.push_back(mk(0, 32'h100, 0, 0, 1, 32'h200, 2'b10));
    for (int i = 0; i < 3; i++) begin
      vecs.push_back(mk(1, 32'h100, 32'h200, 1, 0, 0, 0));
      vecs.push_back(mk(0, 32'h100, 0, 0, 1, 32'h200, 2'b11));
    end
    vecs.push_back(mk(1, 32'h100, 32'h999, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h100, 0, 0, 1, 32'h200, 2'b10));
    vecs.push_back(mk(1, 32'h100, 32'h999, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h100, 0, 0, 1, 32'h200, 2'b01));
    vecs.push_back(mk(1, 32'h100, 32'h999, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h100, 0, 0, 1, 32'h200, 2'b00));
    vecs.push_back(mk(1, 32'h100, 32'h999, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h100, 0, 0, 1, 32'h200, 2'b00));
    vecs.push_back(mk(1, 32'h104, 32'h500, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h104, 0, 0, 0, 32'h0,   2'b01));
    vecs.push_back(mk(0, 32'h140, 0, 0, 0, 32'h0,   2'b01));
    vecs.push_back(mk(1, 32'h140, 32'h300, 1, 0, 0, 0));
    vecs.push_back(mk(0, 32'h140, 0, 0, 1, 32'h300, 2'b10));
    vecs.push_back(mk(0, 32'h100, 0, 0, 0, 32'h0,   2'b01));

    #1;
    do_reset();

    // Initial clear walk with a lookup already waiting.
    lv = 1'b1; lpc = 32'h100;
    #1;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk("init_busy_cycles", 64'(n), 64'd16);
    chk("first_lookup_ready", 64'(lrdy), 64'd1);

    foreach (vecs[i]) begin
      if (vecs[i].is_upd) do_update(vecs[i].pc, vecs[i].tgt, vecs[i].tk, 1'b1);
      else do_lookup(vecs[i].pc, vecs[i].x_hit, vecs[i].x_tgt, vecs[i].x_pred);
    end

    // Lookups held high against a pending update: four wins, one commit slot.
    do_update(32'h180, 32'h400, 1'b1, 1'b0);
    lv = 1'b1; lpc = 32'h180;
    #1;
    for (int i = 0; i < 6; i++) begin
      pat[i] = lrdy;
      tick();
    end
    lv = 1'b0;
    chk("starve_ready_pattern", 64'(pat), 64'(6'b101111));
    do_lookup(32'h180, 1'b1, 32'h400, 2'b10);

    // Flush with an update pending and a lookup in the flush cycle.
    do_update(32'h100, 32'h600, 1'b1, 1'b0);
    fl = 1'b1; lv = 1'b1; lpc = 32'h180;
    #1;
    chk("flush_cycle_lookup_ready", 64'(lrdy), 64'd1);
    chk("flush_cycle_upd_ready", 64'(urdy), 64'd0);
    tick();
    fl = 1'b0; lv = 1'b0;
    chk("flush_cycle_resp_hit", 64'(rhit), 64'd1);
    chk("flush_cycle_resp_target", 64'(rtgt), 64'h400);
    uv = 1'b1; upc = 32'h1c0; utgt = 32'h800; utk = 1'b1;
    #1;
    n = 0;
    while (busy && n < 40) begin
      chk("walk_upd_ready", 64'(urdy), 64'd0);
      tick();
      n++;
    end
    uv = 1'b0;
    chk("flush_busy_cycles", 64'(n), 64'd16);
    do_lookup(32'h100, 1'b0, 32'h0, 2'b01);
    do_lookup(32'h140, 1'b0, 32'h0, 2'b01);
    do_lookup(32'h180, 1'b0, 32'h0, 2'b01);

    // Flush together with an update, then a second flush mid-walk.
    fl = 1'b1; uv = 1'b1; upc = 32'h200; utgt = 32'h700; utk = 1'b1;
    #1;
    chk("flush_upd_same_cycle_ready", 64'(urdy), 64'd0);
    tick();
    fl = 1'b0; uv = 1'b0;
    n = 0;
    while (busy && n < 60) begin
      fl = (n == 7);
      tick();
      n++;
    end
    fl = 1'b0;
    chk("restart_busy_cycles", 64'(n), 64'd24);
    do_lookup(32'h200, 1'b0, 32'h0, 2'b01);

    // Randomized traffic with occasional flushes and one mid-run reset.
    for (int i = 0; i < 600; i++) begin
      lv   = ($urandom_range(0, 3) != 0);
      lpc  = rand_pc();
      uv   = ($urandom_range(0, 1) != 0);
      upc  = rand_pc();
      utgt = $urandom;
      utk  = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 79) == 0);
      if (i == 300) do_reset();
      tick();
    end
    lv = 1'b0; uv = 1'b0; fl = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
